// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction in on one side,
// decoded immediate, format, illegal flag and tag out on the other.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [31:0]      inst_i;
    logic [TAG_W-1:0] tag_i;
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  imm_o;
    logic [2:0]       fmt_o;
    logic             illegal_o;
    logic [TAG_W-1:0] tag_o;

    // Environment side: feeds instructions and consumes decoded entries.
    modport master (
        output valid_i, inst_i, tag_i, ready_i,
        input  ready_o, valid_o, imm_o, fmt_o, illegal_o, tag_o
    );

    // Immediate generator side.
    modport slave (
        input  valid_i, inst_i, tag_i, ready_i,
        output ready_o, valid_o, imm_o, fmt_o, illegal_o, tag_o
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator. The immediate is decoded
// combinationally from the incoming word and registered together with the
// entry; an output register plus one skid register let decode stall
// without dropping or reordering instructions.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input logic         clk_i,
    input logic         rst_n_i,
    imm_gen_pipe_if.slave bus
);

    localparam logic [2:0] FMT_I     = 3'd0;
    localparam logic [2:0] FMT_SHAMT = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_NONE  = 3'd7;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;

    // Every immediate fits a signed 32-bit value; widen it to XLEN.
    function automatic logic signed [XLEN-1:0] sext(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    logic [31:0]        inst;
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic signed [31:0] imm32_p0;
    logic signed [XLEN-1:0] imm_p0;
    logic [2:0]         fmt_p0;
    logic               ill_p0;

    logic                   out_vld_p1;
    logic signed [XLEN-1:0] out_imm_p1;
    logic [2:0]             out_fmt_p1;
    logic                   out_ill_p1;
    logic [TAG_W-1:0]       out_tag_p1;

    logic                   skid_vld_p1;
    logic signed [XLEN-1:0] skid_imm_p1;
    logic [2:0]             skid_fmt_p1;
    logic                   skid_ill_p1;
    logic [TAG_W-1:0]       skid_tag_p1;

    logic accept;

    assign inst   = bus.inst_i;
    assign opc    = inst[6:0];
    assign f3     = inst[14:12];
    assign accept = bus.valid_i && !skid_vld_p1;

    // Stage 0: decode format, illegal flag and raw immediate from the word.
    always_comb begin
        imm32_p0 = '0;
        fmt_p0   = FMT_NONE;
        ill_p0   = 1'b1;
        case (opc)
            OPC_LOAD, OPC_JALR: begin
                imm32_p0 = {{20{inst[31]}}, inst[31:20]};
                fmt_p0   = FMT_I;
                ill_p0   = 1'b0;
            end
            OPC_OPIMM: begin
                ill_p0 = 1'b0;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // shamt is 6 bits only on RV64; never sign-extended
                    imm32_p0 = {26'b0, inst[25] & (XLEN == 64), inst[24:20]};
                    fmt_p0   = FMT_SHAMT;
                end else begin
                    imm32_p0 = {{20{inst[31]}}, inst[31:20]};
                    fmt_p0   = FMT_I;
                end
            end
            OPC_OPIMM32: begin
                if (XLEN == 64) begin
                    ill_p0 = 1'b0;
                    if (f3 == 3'b001 || f3 == 3'b101) begin
                        imm32_p0 = {27'b0, inst[24:20]};
                        fmt_p0   = FMT_SHAMT;
                    end else begin
                        imm32_p0 = {{20{inst[31]}}, inst[31:20]};
                        fmt_p0   = FMT_I;
                    end
                end
            end
            OPC_STORE: begin
                imm32_p0 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                fmt_p0   = FMT_S;
                ill_p0   = 1'b0;
            end
            OPC_BRANCH: begin
                imm32_p0 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                fmt_p0   = FMT_B;
                ill_p0   = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32_p0 = {inst[31:12], 12'b0};
                fmt_p0   = FMT_U;
                ill_p0   = 1'b0;
            end
            OPC_JAL: begin
                imm32_p0 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                fmt_p0   = FMT_J;
                ill_p0   = 1'b0;
            end
            OPC_OP: begin
                ill_p0 = 1'b0;
            end
            default: ;
        endcase
    end

    assign imm_p0 = sext(imm32_p0);

    // Stage 1: output register and skid occupancy; skid drains first to keep order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_vld_p1  <= 1'b0;
            skid_vld_p1 <= 1'b0;
            out_imm_p1  <= '0;
            out_fmt_p1  <= FMT_NONE;
            out_ill_p1  <= 1'b0;
            out_tag_p1  <= '0;
        end else if (skid_vld_p1) begin
            if (bus.ready_i) begin
                out_imm_p1  <= skid_imm_p1;
                out_fmt_p1  <= skid_fmt_p1;
                out_ill_p1  <= skid_ill_p1;
                out_tag_p1  <= skid_tag_p1;
                out_vld_p1  <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end
        end else if (accept) begin
            if (!out_vld_p1 || bus.ready_i) begin
                out_imm_p1 <= imm_p0;
                out_fmt_p1 <= fmt_p0;
                out_ill_p1 <= ill_p0;
                out_tag_p1 <= bus.tag_i;
                out_vld_p1 <= 1'b1;
            end else begin
                skid_vld_p1 <= 1'b1;
            end
        end else if (bus.ready_i) begin
            out_vld_p1 <= 1'b0;
        end
    end

    // Stage 1: skid payload, captured only when the output register is held.
    always_ff @(posedge clk_i) begin
        if (accept && out_vld_p1 && !bus.ready_i) begin
            skid_imm_p1 <= imm_p0;
            skid_fmt_p1 <= fmt_p0;
            skid_ill_p1 <= ill_p0;
            skid_tag_p1 <= bus.tag_i;
        end
    end

    assign bus.ready_o   = !skid_vld_p1;
    assign bus.valid_o   = out_vld_p1;
    assign bus.imm_o     = out_imm_p1;
    assign bus.fmt_o     = out_fmt_p1;
    assign bus.illegal_o = out_ill_p1;
    assign bus.tag_o     = out_tag_p1;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator; successor to the combinational I-type/shamt sign-extender. Decodes the immediate of every RV32I/RV64I format (I, I-shift, S, B, U, J) from a full instruction word and sign- or zero-extends it to XLEN. Sits between the IF/ID register and the ID/EX register. Uses a valid/ready handshake with a 2-entry skid buffer, so decode can stall without dropping instructions.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
TAG_W, 32, width of the sideband tag (normally the PC), carried unchanged.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_n_i  input  1  asynchronous, active-low reset.
valid_i  input  1  upstream has an instruction.
ready_o  output  1  block can accept; registered output.
inst_i  input  32  instruction word.
tag_i  input  TAG_W  sideband tag.
valid_o  output  1  output entry valid.
ready_i  input  1  downstream accepts.
imm_o  output  XLEN  extended immediate.
fmt_o  output  3  format code: 0=I, 1=SHAMT, 2=S, 3=B, 4=U, 5=J, 7=NONE.
illegal_o  output  1  opcode carries no immediate or is unsupported.
tag_o  output  TAG_W  tag of the output entry.

Behaviour:
- Reset is asynchronous, active-low, and one clock domain only.
- While rst_n_i is low: valid_o=0, ready_o=1, imm_o=0, fmt_o=7, illegal_o=0, tag_o=0, skid buffer empty.
- Asserting reset mid-stream discards both entries immediately, without waiting for a clock edge.
- A transfer in happens when valid_i && ready_o at a clock edge. A transfer out happens when valid_o && ready_i.
- Latency: an accepted instruction appears on the outputs on the next cycle.
- Throughput: 1 instruction per cycle while ready_i=1.
- Storage is an output register plus one skid register. ready_o = skid empty, and is registered.
- Output register empty, or being drained this cycle: the incoming entry loads the output register.
- Output register held (valid_o && !ready_i) and an entry is accepted: the entry goes to the skid register, and ready_o drops the next cycle.
- Skid full and ready_i=1: the skid entry moves to the output register, and ready_o rises the next cycle.
- Outputs are stable while valid_o && !ready_i. Order is strictly preserved.
- Decode is combinational on inst_i and is registered with the entry.
- Opcode 0000011 (LOAD) or 1100111 (JALR): I format; imm = sext(inst[31:20]).
- Opcode 0010011 (OP-IMM), funct3 not 001/101: I format.
- Opcode 0010011, funct3 001 or 101: SHAMT format. imm = zero-extended shamt: inst[24:20] for XLEN=32, inst[25:20] for XLEN=64. funct7 bits are ignored. The shamt is never sign-extended.
- Opcode 0011011 (OP-IMM-32), XLEN=64 only: I or SHAMT format as above, with a 5-bit shamt. With XLEN=32 this opcode is illegal.
- Opcode 0100011 (STORE): S format; imm = sext({inst[31:25], inst[11:7]}).
- Opcode 1100011 (BRANCH): B format; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
- Opcode 0110111 or 0010111 (LUI/AUIPC): U format; imm = sext({inst[31:12], 12'b0}), so the upper bits replicate inst[31] when XLEN=64.
- Opcode 1101111 (JAL): J format; imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- Opcode 0110011 (OP), and any other opcode: fmt=7, imm=0. illegal_o=1 for any opcode outside the lists above. OP gives fmt=7 with illegal_o=0.
- An illegal entry still flows through the handshake normally; it is never dropped.
- valid_i=0 with ready_o=1: no state change.
- valid_i is ignored while ready_o=0; upstream must hold its data.

Test Plan:
- Reset, then addi x1,x0,-1 (0xFFF00093) with ready_i=1 -> next cycle valid_o=1, imm_o=0xFFFFFFFF, fmt_o=0, illegal_o=0.
- srai x1,x2,31 (0x41F15093) -> imm_o=0x0000001F and fmt_o=1. With XLEN=64, 0x43F15093 -> imm_o=0x3F.
- sw x5,-4(x2) (0xFE512E23) -> imm_o=0xFFFFFFFC, fmt_o=2. lui x1,0x12345 (0x123450B7) -> 0x12345000, fmt_o=4. With XLEN=64, 0x800000B7 -> 0xFFFFFFFF80000000.
- Backpressure: hold ready_i=0 and offer 3 tagged instructions with tags 0x100/0x104/0x108 -> the first two are accepted and ready_o=0 from the cycle after the second. Release ready_i -> tags come out 0x100, 0x104, 0x108 in order, none lost or duplicated, and outputs are stable while stalled.
- Opcode 0x7F (inst 0x0000007F) -> illegal_o=1, imm_o=0, fmt_o=7, still handshaken out. add (0x002081B3) -> fmt_o=7, illegal_o=0.
- With both entries full, drive rst_n_i low between clock edges -> valid_o=0 and ready_o=1 immediately. After release, a new instruction is processed with a 1-cycle latency.
